// File: rtl/ecpri_tx_if.sv
// Bundle of request fields, header/payload RAM read ports and packet RAM
// write port of ecpri_tx. master = requester/memory side, slave = ecpri_tx.
interface ecpri_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  send_read_resp;
  logic                  send_write_resp;
  logic [7:0]            resp_payload_len;
  logic [7:0]            rm_acc_id;
  logic [15:0]           rm_ele_id;
  logic [47:0]           rm_addr;
  logic [ADDR_WIDTH-1:0] addr_h;
  logic                  oe_h;
  logic [DATA_WIDTH-1:0] data_h;
  logic [ADDR_WIDTH-1:0] addr_p;
  logic                  oe_p;
  logic [DATA_WIDTH-1:0] data_p;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic [DATA_WIDTH-1:0] data_0;
  logic                  we_0;
  logic                  busy;
  logic                  tx_done;
  logic [15:0]           tx_len;

  modport master (
    output send_read_resp, send_write_resp, resp_payload_len,
           rm_acc_id, rm_ele_id, rm_addr, data_h, data_p,
    input  addr_h, oe_h, addr_p, oe_p, addr_0, data_0, we_0,
           busy, tx_done, tx_len
  );

  modport slave (
    input  send_read_resp, send_write_resp, resp_payload_len,
           rm_acc_id, rm_ele_id, rm_addr, data_h, data_p,
    output addr_h, oe_h, addr_p, oe_p, addr_0, data_0, we_0,
           busy, tx_done, tx_len
  );
endinterface

// File: rtl/ecpri_tx.sv
// eCPRI remote-memory read/write response builder, one byte per cycle into the
// transmit packet RAM. Define ECPRI_TX_VLAN_EN to insert an 802.1Q tag.
module ecpri_tx #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  ECPRI_REV  = 8'h10,
  parameter logic [15:0] VLAN_TCI   = 16'h0000
) (
  input logic       clk,
  input logic       reset,
  ecpri_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ETH_HDR   = 3'd1,
`ifdef ECPRI_TX_VLAN_EN
    VLAN_TAG  = 3'd2,
`endif
    ETYPE     = 3'd3,
    ECPRI_HDR = 3'd4,
    RM_HDR    = 3'd5,
    PAYLOAD   = 3'd6,
    DONE      = 3'd7
  } state_e;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_H   = 2'd1;
  localparam logic [1:0] SEL_P   = 2'd2;

  state_e                state_q;
  logic [7:0]            cnt_q, len_q, acc_q;
  logic [15:0]           pos_q, ele_q, tx_len_q;
  logic [47:0]           raddr_q;
  logic                  is_read_q, pending_q, busy_q, tx_done_q;
  logic                  we_0_q, oe_h_q, oe_p_q;
  logic [ADDR_WIDTH-1:0] addr_h_q, addr_p_q, addr_0_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            sel_q, sel_d;
  logic                  emit_d;
  logic [7:0]            byte_d;
  logic [15:0]           size_d;

  assign size_d = 16'd12 + {8'd0, len_q};

`ifndef ECPRI_TX_VLAN_EN
  logic unused_tci;
  assign unused_tci = ^VLAN_TCI;
`endif

  // Byte to emit in the current state; RAM-sourced bytes are selected at the output.
  always_comb begin
    emit_d = 1'b1;
    sel_d  = SEL_REG;
    byte_d = 8'h00;
    case (state_q)
      ETH_HDR: sel_d = SEL_H;
`ifdef ECPRI_TX_VLAN_EN
      VLAN_TAG: begin
        case (cnt_q[1:0])
          2'd0:    byte_d = 8'h81;
          2'd1:    byte_d = 8'h00;
          2'd2:    byte_d = VLAN_TCI[15:8];
          default: byte_d = VLAN_TCI[7:0];
        endcase
      end
`endif
      ETYPE: byte_d = cnt_q[0] ? 8'hFE : 8'hAE;
      ECPRI_HDR: begin
        case (cnt_q[1:0])
          2'd0:    byte_d = ECPRI_REV;
          2'd1:    byte_d = 8'h04;
          2'd2:    byte_d = size_d[15:8];
          default: byte_d = size_d[7:0];
        endcase
      end
      RM_HDR: begin
        case (cnt_q[3:0])
          4'd0:    byte_d = acc_q;
          4'd1:    byte_d = is_read_q ? 8'h02 : 8'h03;
          4'd2:    byte_d = ele_q[15:8];
          4'd3:    byte_d = ele_q[7:0];
          4'd4:    byte_d = raddr_q[47:40];
          4'd5:    byte_d = raddr_q[39:32];
          4'd6:    byte_d = raddr_q[31:24];
          4'd7:    byte_d = raddr_q[23:16];
          4'd8:    byte_d = raddr_q[15:8];
          4'd9:    byte_d = raddr_q[7:0];
          4'd10:   byte_d = 8'h00;
          default: byte_d = len_q;
        endcase
      end
      PAYLOAD: sel_d = SEL_P;
      default: emit_d = 1'b0;
    endcase
  end

  // Packet sequencer: RAM reads are issued one cycle ahead of the byte they feed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      acc_q     <= 8'd0;
      pos_q     <= 16'd0;
      ele_q     <= 16'd0;
      tx_len_q  <= 16'd0;
      raddr_q   <= 48'd0;
      is_read_q <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      we_0_q    <= 1'b0;
      oe_h_q    <= 1'b0;
      oe_p_q    <= 1'b0;
      addr_h_q  <= '0;
      addr_p_q  <= '0;
      addr_0_q  <= '0;
      data_q    <= '0;
      sel_q     <= SEL_REG;
    end else begin
      we_0_q    <= emit_d;
      tx_done_q <= 1'b0;
      sel_q     <= sel_d;
      if (emit_d) begin
        addr_0_q <= ADDR_WIDTH'(pos_q);
        pos_q    <= pos_q + 16'd1;
        data_q   <= DATA_WIDTH'(byte_d);
      end
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (pending_q || (!busy_q && (bus.send_read_resp || bus.send_write_resp))) begin
            state_q  <= ETH_HDR;
            cnt_q    <= 8'd0;
            pos_q    <= 16'd0;
            oe_h_q   <= 1'b1;
            addr_h_q <= '0;
            busy_q   <= 1'b1;
            if (pending_q) begin
              // Deferred write reuses the fields latched with the read.
              is_read_q <= 1'b0;
              len_q     <= 8'd0;
              pending_q <= 1'b0;
            end else begin
              acc_q     <= bus.rm_acc_id;
              ele_q     <= bus.rm_ele_id;
              raddr_q   <= bus.rm_addr;
              is_read_q <= bus.send_read_resp;
              len_q     <= bus.send_read_resp ? bus.resp_payload_len : 8'd0;
              pending_q <= bus.send_read_resp & bus.send_write_resp;
            end
          end
        end
        ETH_HDR: begin
          if (cnt_q == 8'd11) begin
            cnt_q    <= 8'd0;
            oe_h_q   <= 1'b0;
            addr_h_q <= '0;
`ifdef ECPRI_TX_VLAN_EN
            state_q  <= VLAN_TAG;
`else
            state_q  <= ETYPE;
`endif
          end else begin
            cnt_q    <= cnt_q + 8'd1;
            addr_h_q <= ADDR_WIDTH'(cnt_q + 8'd1);
          end
        end
`ifdef ECPRI_TX_VLAN_EN
        VLAN_TAG: begin
          cnt_q   <= (cnt_q == 8'd3) ? 8'd0 : cnt_q + 8'd1;
          state_q <= (cnt_q == 8'd3) ? ETYPE : VLAN_TAG;
        end
`endif
        ETYPE: begin
          cnt_q   <= (cnt_q == 8'd1) ? 8'd0 : cnt_q + 8'd1;
          state_q <= (cnt_q == 8'd1) ? ECPRI_HDR : ETYPE;
        end
        ECPRI_HDR: begin
          cnt_q   <= (cnt_q == 8'd3) ? 8'd0 : cnt_q + 8'd1;
          state_q <= (cnt_q == 8'd3) ? RM_HDR : ECPRI_HDR;
        end
        RM_HDR: begin
          if (cnt_q == 8'd11) begin
            cnt_q <= 8'd0;
            if (is_read_q && (len_q != 8'd0)) begin
              oe_p_q   <= 1'b1;
              addr_p_q <= '0;
              state_q  <= PAYLOAD;
            end else begin
              state_q  <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PAYLOAD: begin
          if ((cnt_q + 8'd1) == len_q) begin
            oe_p_q   <= 1'b0;
            addr_p_q <= '0;
            state_q  <= DONE;
          end else begin
            cnt_q    <= cnt_q + 8'd1;
            addr_p_q <= ADDR_WIDTH'(cnt_q + 8'd1);
          end
        end
        DONE: begin
          tx_done_q <= 1'b1;
          tx_len_q  <= pos_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr_h  = addr_h_q;
  assign bus.oe_h    = oe_h_q;
  assign bus.addr_p  = addr_p_q;
  assign bus.oe_p    = oe_p_q;
  assign bus.addr_0  = addr_0_q;
  assign bus.we_0    = we_0_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;
  assign bus.tx_len  = tx_len_q;
  assign bus.data_0  = (sel_q == SEL_H) ? bus.data_h :
                       (sel_q == SEL_P) ? bus.data_p : data_q;

endmodule

// File: tb/tb_ecpri_tx.sv
// Self-checking bench for ecpri_tx: RAM models, packet capture and a
// field-level reference model of the response frame.
module tb_ecpri_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  localparam logic [15:0] TCI = 16'h0064;
`ifdef ECPRI_TX_VLAN_EN
  localparam int VL = 4;
`else
  localparam int VL = 0;
`endif

  ecpri_tx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();
  ecpri_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ECPRI_REV(8'h10), .VLAN_TCI(TCI))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] mem_h [12];
  logic [7:0] mem_p [256];
  logic [7:0] cap [$];
  int         cap_addr [$];
  int         done_len [$];
  int         oe_p_cycles = 0;
  logic [7:0] exp_b [$];
  int         exp_a [$];

  // Header and payload RAMs: 1-cycle read latency.
  always @(posedge clk) begin
    if (reset) begin
      bus.data_h <= 8'h00;
      bus.data_p <= 8'h00;
    end else begin
      if (bus.oe_h) bus.data_h <= (bus.addr_h < 16'd12) ? mem_h[bus.addr_h[3:0]] : 8'h00;
      if (bus.oe_p) bus.data_p <= mem_p[bus.addr_p[7:0]];
    end
  end

  // Packet RAM writes and completion pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we_0) begin
      cap.push_back(bus.data_0);
      cap_addr.push_back(int'(bus.addr_0));
    end
    if (bus.tx_done) done_len.push_back(int'(bus.tx_len));
    if (bus.oe_p) oe_p_cycles++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap.delete(); cap_addr.delete(); done_len.delete();
    exp_b.delete(); exp_a.delete();
    oe_p_cycles = 0;
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 12; i++) mem_h[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem_p[i] = 8'($urandom);
  endtask

  // Reference frame: MAC header, optional tag, ethertype, eCPRI header, RM header, payload.
  function automatic void build_exp(input bit rd, input int n, input logic [7:0] acc,
                                    input logic [15:0] ele, input logic [47:0] ad);
    int base = exp_b.size();
    int sz = 12 + n;
    for (int i = 0; i < 12; i++) exp_b.push_back(mem_h[i]);
    if (VL == 4) begin
      exp_b.push_back(8'h81); exp_b.push_back(8'h00);
      exp_b.push_back(TCI[15:8]); exp_b.push_back(TCI[7:0]);
    end
    exp_b.push_back(8'hAE); exp_b.push_back(8'hFE);
    exp_b.push_back(8'h10); exp_b.push_back(8'h04);
    exp_b.push_back(8'(sz >> 8)); exp_b.push_back(8'(sz));
    exp_b.push_back(acc); exp_b.push_back(rd ? 8'h02 : 8'h03);
    exp_b.push_back(ele[15:8]); exp_b.push_back(ele[7:0]);
    for (int k = 5; k >= 0; k--) exp_b.push_back(ad[8*k +: 8]);
    exp_b.push_back(8'(n >> 8)); exp_b.push_back(8'(n));
    if (rd) for (int i = 0; i < n; i++) exp_b.push_back(mem_p[i]);
    for (int i = base; i < exp_b.size(); i++) exp_a.push_back(i - base);
  endfunction

  function automatic int first_diff();
    int m = (cap.size() < exp_b.size()) ? cap.size() : exp_b.size();
    for (int i = 0; i < m; i++)
      if (cap[i] !== exp_b[i] || cap_addr[i] != exp_a[i]) return i;
    if (cap.size() != exp_b.size()) return m;
    return -1;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [7:0] n, input logic [7:0] acc,
                       input logic [15:0] ele, input logic [47:0] ad);
    bus.send_read_resp = rd; bus.send_write_resp = wr;
    bus.resp_payload_len = n; bus.rm_acc_id = acc; bus.rm_ele_id = ele; bus.rm_addr = ad;
    tick();
    bus.send_read_resp = 1'b0; bus.send_write_resp = 1'b0;
    bus.resp_payload_len = 8'($urandom); bus.rm_acc_id = 8'($urandom);
    bus.rm_ele_id = 16'($urandom); bus.rm_addr = 48'({$urandom, $urandom});
  endtask

  task automatic wait_done(input int cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done_len.size() >= cnt) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_total++;
    if ({bus.busy, bus.tx_done, bus.we_0, bus.oe_h, bus.oe_p} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {bus.busy, bus.tx_done, bus.we_0, bus.oe_h, bus.oe_p});
    else n_pass++;
    n_total++;
    if ({bus.addr_0, bus.addr_h, bus.addr_p, bus.tx_len} !== 64'd0)
      $display("FAIL reset_buses: got %h expected 0", {bus.addr_0, bus.addr_h, bus.addr_p, bus.tx_len});
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_timing();
    bit ok; int d;
    clear_mon(); fill_mems();
    build_exp(1'b1, 3, 8'h5A, 16'hBEEF, 48'h0123_4567_89AB);
    bus.send_read_resp = 1'b1; bus.resp_payload_len = 8'd3;
    bus.rm_acc_id = 8'h5A; bus.rm_ele_id = 16'hBEEF; bus.rm_addr = 48'h0123_4567_89AB;
    tick();
    bus.send_read_resp = 1'b0; bus.resp_payload_len = 8'd77;
    n_total++;
    if ({bus.busy, bus.oe_h, bus.we_0} !== 3'b110 || bus.addr_h !== 16'd0)
      $display("FAIL start_T1: got busy/oe_h/we_0=%b addr_h=%0d expected 110 0", {bus.busy, bus.oe_h, bus.we_0}, bus.addr_h);
    else n_pass++;
    tick();
    n_total++;
    if (bus.we_0 !== 1'b1 || bus.addr_0 !== 16'd0)
      $display("FAIL first_byte_T2: got we_0=%b addr_0=%0d expected 1 0", bus.we_0, bus.addr_0);
    else n_pass++;
    wait_done(1, ok);
    n_total++;
    if (!ok) $display("FAIL timing_done: got no tx_done expected one"); else n_pass++;
    n_total++;
    if (done_len.size() > 0 && done_len[0] != 33 + VL)
      $display("FAIL timing_len: got %0d expected %0d", done_len[0], 33 + VL);
    else n_pass++;
    tick();
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", bus.busy); else n_pass++;
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL timing_bytes: got mismatch at byte %0d (size %0d) expected %0d bytes", d, cap.size(), exp_b.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_read_spec();
    bit ok; int d;
    logic [7:0] want [6];
    clear_mon(); fill_mems();
    mem_p[0] = 8'hDE; mem_p[1] = 8'hAD; mem_p[2] = 8'hBE; mem_p[3] = 8'hEF;
    want = '{8'hAE, 8'hFE, 8'h10, 8'h04, 8'h00, 8'h10};
    build_exp(1'b1, 4, 8'h01, 16'h0102, 48'h0000_0000_1000);
    issue(1'b1, 1'b0, 8'd4, 8'h01, 16'h0102, 48'h0000_0000_1000);
    wait_done(1, ok);
    n_total++;
    if (!ok || cap.size() != 34 + VL) $display("FAIL read_size: got %0d bytes expected %0d", cap.size(), 34 + VL);
    else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_total++;
        if (cap[12 + VL + i] !== want[i]) $display("FAIL read_hdr_byte%0d: got %h expected %h", 12 + VL + i, cap[12 + VL + i], want[i]);
        else n_pass++;
      end
      n_total++;
      if (cap[19 + VL] !== 8'h02) $display("FAIL read_type: got %h expected 02", cap[19 + VL]); else n_pass++;
      n_total++;
      if ({cap[30 + VL], cap[31 + VL], cap[32 + VL], cap[33 + VL]} !== 32'hDEADBEEF)
        $display("FAIL read_payload: got %h%h%h%h expected deadbeef", cap[30 + VL], cap[31 + VL], cap[32 + VL], cap[33 + VL]);
      else n_pass++;
      n_total++;
      if (done_len[0] != 34 + VL) $display("FAIL read_tx_len: got %0d expected %0d", done_len[0], 34 + VL); else n_pass++;
    end
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL read_bytes: got mismatch at byte %0d expected none", d); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_write_spec();
    bit ok;
    clear_mon(); fill_mems();
    build_exp(1'b0, 0, 8'h01, 16'h0102, 48'h0000_0000_1000);
    issue(1'b0, 1'b1, 8'd9, 8'h01, 16'h0102, 48'h0000_0000_1000);
    wait_done(1, ok);
    n_total++;
    if (!ok || done_len[0] != 30 + VL) $display("FAIL write_tx_len: got %0d expected %0d", ok ? done_len[0] : -1, 30 + VL);
    else n_pass++;
    n_total++;
    if (cap.size() != 30 + VL || cap[19 + VL] !== 8'h03 || cap[28 + VL] !== 8'h00 || cap[29 + VL] !== 8'h00)
      $display("FAIL write_fields: got size %0d expected %0d with type 03 length 0000", cap.size(), 30 + VL);
    else n_pass++;
    n_total++;
    if (oe_p_cycles != 0) $display("FAIL write_oe_p: got %0d cycles expected 0", oe_p_cycles); else n_pass++;
    n_total++;
    if (first_diff() >= 0) $display("FAIL write_bytes: got mismatch at byte %0d expected none", first_diff()); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    bit ok;
    clear_mon(); fill_mems();
    build_exp(1'b1, 2, 8'hC3, 16'h7E01, 48'hA1A2_A3A4_A5A6);
    build_exp(1'b0, 0, 8'hC3, 16'h7E01, 48'hA1A2_A3A4_A5A6);
    issue(1'b1, 1'b1, 8'd2, 8'hC3, 16'h7E01, 48'hA1A2_A3A4_A5A6);
    wait_done(2, ok);
    n_total++;
    if (!ok) $display("FAIL simul_done: got %0d pulses expected 2", done_len.size()); else n_pass++;
    n_total++;
    if (ok && (done_len[0] != 32 + VL || done_len[1] != 30 + VL))
      $display("FAIL simul_lens: got %0d,%0d expected %0d,%0d", done_len[0], done_len[1], 32 + VL, 30 + VL);
    else n_pass++;
    n_total++;
    if (cap.size() != 62 + 2 * VL || cap[32 + 2 * VL + 19] !== 8'h03)
      $display("FAIL simul_second_type: got size %0d expected %0d with type 03", cap.size(), 62 + 2 * VL);
    else n_pass++;
    n_total++;
    if (first_diff() >= 0) $display("FAIL simul_bytes: got mismatch at byte %0d expected none", first_diff()); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [7:0] n = 8'($urandom_range(1, 20));
    clear_mon(); fill_mems();
    build_exp(1'b1, int'(n), 8'h11, 16'h2233, 48'h4455_6677_8899);
    issue(1'b1, 1'b0, n, 8'h11, 16'h2233, 48'h4455_6677_8899);
    repeat (5) tick();
    issue(1'b0, 1'b1, 8'd0, 8'hFF, 16'hFFFF, 48'hFFFF_FFFF_FFFF);
    wait_done(1, ok);
    repeat (80) tick();
    n_total++;
    if (done_len.size() != 1) $display("FAIL busy_pulses: got %0d expected 1", done_len.size()); else n_pass++;
    n_total++;
    if (first_diff() >= 0) $display("FAIL busy_bytes: got mismatch at byte %0d expected none", first_diff()); else n_pass++;
  endtask

  task automatic test_mid_reset();
    clear_mon(); fill_mems();
    issue(1'b1, 1'b0, 8'd8, 8'h21, 16'h4321, 48'h0000_0000_0042);
    for (int i = 0; i < 100 && cap.size() < 21; i++) tick();
    n_total++;
    if (cap.size() != 21) $display("FAIL abort_reach: got %0d bytes expected 21", cap.size()); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if ({bus.we_0, bus.busy, bus.tx_done, bus.oe_h, bus.oe_p} !== 5'b0)
      $display("FAIL abort_flags: got %b expected 00000", {bus.we_0, bus.busy, bus.tx_done, bus.oe_h, bus.oe_p});
    else n_pass++;
    n_total++;
    if ({bus.addr_0, bus.addr_h, bus.addr_p, bus.data_0, bus.tx_len} !== 72'd0)
      $display("FAIL abort_buses: got %h expected 0", {bus.addr_0, bus.addr_h, bus.addr_p, bus.data_0, bus.tx_len});
    else n_pass++;
    reset = 1'b0;
    repeat (60) tick();
    n_total++;
    if (done_len.size() != 0 || cap.size() != 21)
      $display("FAIL abort_quiet: got %0d done, %0d bytes expected 0, 21", done_len.size(), cap.size());
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok, rd;
    int n;
    logic [7:0] acc; logic [15:0] ele; logic [47:0] ad;
    for (int t = 0; t < 7; t++) begin
      clear_mon(); fill_mems();
      rd  = (t < 3) ? 1'b1 : 1'($urandom);
      n   = (t == 0) ? 0 : (t == 1) ? 255 : (t == 2) ? 1 : int'($urandom_range(0, 40));
      acc = 8'($urandom); ele = 16'($urandom); ad = 48'({$urandom, $urandom});
      build_exp(rd, rd ? n : 0, acc, ele, ad);
      issue(rd, ~rd, 8'(n), acc, ele, ad);
      wait_done(1, ok);
      n_total++;
      if (!ok || done_len[0] != exp_b.size())
        $display("FAIL rand%0d_len: got %0d expected %0d", t, ok ? done_len[0] : -1, exp_b.size());
      else n_pass++;
      n_total++;
      if (first_diff() >= 0) $display("FAIL rand%0d_bytes: got mismatch at byte %0d expected none", t, first_diff());
      else n_pass++;
      n_total++;
      if (oe_p_cycles != (rd ? n : 0)) $display("FAIL rand%0d_oe_p: got %0d expected %0d", t, oe_p_cycles, rd ? n : 0);
      else n_pass++;
`ifdef ECPRI_TX_VLAN_EN
      if (t == 0) begin
        n_total++;
        if ({cap[12], cap[13], cap[14], cap[15], cap[16], cap[17]} !== 48'h8100_0064_AEFE)
          $display("FAIL vlan_tag: got %h%h%h%h%h%h expected 81000064aefe", cap[12], cap[13], cap[14], cap[15], cap[16], cap[17]);
        else n_pass++;
      end
`endif
      repeat (2) tick();
    end
  endtask

  initial begin
    bus.send_read_resp = 1'b0; bus.send_write_resp = 1'b0;
    bus.resp_payload_len = 8'd0; bus.rm_acc_id = 8'd0;
    bus.rm_ele_id = 16'd0; bus.rm_addr = 48'd0;
    fill_mems();
    test_reset();
    test_timing();
    test_read_spec();
    test_write_spec();
    test_simultaneous();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ecpri_tx.md
ECPRI_TX -- requirements
Module: ecpri_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte-lane width of all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, width of all RAM address ports.
REQ-003 SHALL have parameter ECPRI_REV, default 8'h10, first byte of the eCPRI common header (revision 1, C=0).
REQ-004 SHALL have parameter VLAN_TCI, default 16'h0000, 802.1Q tag control field when VLAN is compiled in.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 send_read_resp / send_write_resp  in  1 each  request to build a read / write response, sampled high for one cycle.
REQ-008 resp_payload_len  in  8  read-response payload byte count N; 0 is legal.
REQ-009 rm_acc_id  in  8; rm_ele_id  in  16; rm_addr  in  48  remote-memory header fields, sampled with the request.
REQ-010 addr_h / oe_h  out  ADDR_WIDTH / 1; data_h  in  8  Ethernet MAC header RAM (bytes 0-11), 1-cycle read latency.
REQ-011 addr_p / oe_p  out  ADDR_WIDTH / 1; data_p  in  8  read-payload RAM, 1-cycle read latency.
REQ-012 addr_0 / data_0 / we_0  out  ADDR_WIDTH / 8 / 1  transmit packet RAM write port.
REQ-013 busy  out  1; tx_done  out  1 (one-cycle pulse); tx_len  out  16 (total bytes written, valid with tx_done).

Function
REQ-014 States SHALL be IDLE, ETH_HDR, VLAN_TAG, ETYPE, ECPRI_HDR, RM_HDR, PAYLOAD, DONE; VLAN_TAG exists only under the macro.
REQ-015 IDLE: a request at cycle T SHALL latch all fields and leave IDLE at T+1 with busy=1; oe_h asserted at T+1, addr_h=0.
REQ-016 Packet SHALL be written one byte per cycle, contiguous, addr_0 starting at 0 at cycle T+2, we_0=1 only for written bytes.
REQ-017 ETH_HDR: bytes 0-11 = data_h for addr_h 0-11, fetched one cycle ahead.
REQ-018 ETYPE: 8'hAE then 8'hFE.
REQ-019 ECPRI_HDR: ECPRI_REV, 8'h04, then payload size {12+N} as 16 bits big-endian; N=0 for write response.
REQ-020 RM_HDR: rm_acc_id; 8'h02 (read resp) or 8'h03 (write resp); rm_ele_id, rm_addr, length field (N, 16-bit) all big-endian, 12 bytes total.
REQ-021 PAYLOAD (read resp, N>0 only): N bytes of data_p from addr_p 0..N-1, oe_p asserted one cycle before each byte is needed; skipped when N=0 or write resp.
REQ-022 DONE: tx_done=1 for one cycle, tx_len=30+N (34+N with VLAN), busy=0 next cycle, return IDLE.
REQ-023 Simultaneous send_read_resp and send_write_resp: read response built first; write request latched pending and started the cycle after DONE.
REQ-024 Requests arriving while busy=1 SHALL be ignored (except REQ-023 pending).
REQ-025 Address counters SHALL NOT wrap within a packet; max packet 289 bytes.

Reset
REQ-026 reset SHALL force IDLE, clear pending flag, and drive all outputs to 0 (addr, data, we, oe, busy, tx_done, tx_len) on the next edge.
REQ-027 reset mid-packet SHALL abort: no further we_0, no tx_done.

Configuration
REQ-028 Macro ECPRI_TX_VLAN_EN defined: VLAN_TAG state inserts 8'h81, 8'h00, VLAN_TCI[15:8], VLAN_TCI[7:0] after byte 11; later bytes shift by 4.
REQ-029 Macro undefined: no tag, ETYPE follows ETH_HDR directly, tx_len=30+N.

Verification
REQ-030 Read resp N=4, acc 8'h01, ele 16'h0102, addr 48'h0000_0000_1000, payload DE AD BE EF -> bytes 12-17 AE FE 10 04 00 10, byte 19=02, bytes 30-33 DE AD BE EF, tx_len=34.
REQ-031 Write resp, same fields -> byte 19=03, length bytes 28-29=00 00, tx_len=30, oe_p never asserted.
REQ-032 Simultaneous read (N=2) and write requests -> two tx_done pulses, tx_len 32 then 30, second packet type 03.
REQ-033 reset asserted at byte 20 of a read resp -> we_0 low next cycle, no tx_done, busy=0.
REQ-034 ECPRI_TX_VLAN_EN, VLAN_TCI=16'h0064, read N=0 -> bytes 12-15 81 00 00 64, bytes 16-17 AE FE, tx_len=34.
REQ-035 Request during busy -> ignored, exactly one tx_done.
